factorizer_serial: RTL and testbench

Parametrised, bit-serial successor to the fixed 8-bit factorizer. It accepts one WIDTH-bit unsigned number over a valid/ready handshake. It then computes divisibility by every divisor 2..MAX_DIV by streaming the number MSB-first through one residue accumulator per divisor, and returns a registered factor mask over a second valid/ready handshake. It sits between a number source, such as an input register or counter, and any consumer of the factor mask, such as a display or scoreboard.

---
 rtl/factorizer_pkg.sv | 15 +
 rtl/factorizer_residue.sv | 40 ++++
 rtl/factorizer_serial.sv | 128 ++++++++++++
 tb/tb_factorizer_serial.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/factorizer_pkg.sv
// Shared types and helpers for the bit-serial factorizer.
package factorizer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bits needed to hold a residue modulo div (values 0..div-1).
  function automatic int res_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/factorizer_residue.sv
// One MSB-first residue accumulator: r <= (2r + bit) mod DIV, with a zero flag on the next value.
module factorizer_residue
  import factorizer_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic step_i,
  input  logic bit_i,
  output logic zero_next_o
);

  localparam int RW = res_width(DIV);

  logic [RW-1:0] res_q;
  logic [RW-1:0] res_d;
  logic [RW:0]   dbl;

  // 2r+b < 2*DIV, so a single conditional subtract reduces it.
  always_comb begin
    dbl = {res_q, bit_i};
    if (dbl >= (RW+1)'(DIV)) begin
      res_d = RW'(dbl - (RW+1)'(DIV));
    end else begin
      res_d = dbl[RW-1:0];
    end
    zero_next_o = (res_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      res_q <= '0;
    end else if (step_i) begin
      res_q <= res_d;
    end
  end

endmodule

// File: rtl/factorizer_serial.sv
// Bit-serial factorizer: tests divisibility of a WIDTH-bit number by 2..MAX_DIV.
// Optional popcount output enabled by defining FACTORIZER_COUNT_EN.
module factorizer_serial
  import factorizer_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_DIV = 9
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           number,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [MAX_DIV-2:0]         factors
`ifdef FACTORIZER_COUNT_EN
  ,
  output logic [$clog2(MAX_DIV)-1:0] factor_count
`endif
);

  localparam int NUM_DIV = MAX_DIV - 1;
  localparam int BCW     = $clog2(WIDTH);

  state_e             state_q;
  logic [WIDTH-1:0]   shreg_q;
  logic [BCW-1:0]     cnt_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [NUM_DIV-1:0] factors_q;
  logic [NUM_DIV-1:0] zero_next;
  logic               accept;
  logic               step;
  logic               last_step;

  // in_ready_q is only ever set while in IDLE, so it doubles as the state qualifier.
  assign accept    = in_ready_q & in_valid;
  assign step      = (state_q == RUN);
  assign last_step = step && (cnt_q == '0);

  generate
    for (genvar gi = 0; gi < NUM_DIV; gi++) begin : g_res
      factorizer_residue #(
        .DIV(gi + 2)
      ) u_res (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (accept),
        .step_i     (step),
        .bit_i      (shreg_q[WIDTH-1]),
        .zero_next_o(zero_next[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      factors_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            shreg_q    <= number;
            cnt_q      <= BCW'(WIDTH - 1);
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        RUN: begin
          shreg_q <= shreg_q << 1;
          cnt_q   <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            factors_q   <= zero_next;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign factors   = factors_q;

`ifdef FACTORIZER_COUNT_EN
  localparam int CW = $clog2(MAX_DIV);

  logic [CW-1:0] count_q;
  logic [CW-1:0] popcnt;

  always_comb begin
    popcnt = '0;
    for (int i = 0; i < NUM_DIV; i++) begin
      popcnt = popcnt + CW'(zero_next[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (last_step) begin
      count_q <= popcnt;
    end
  end

  assign factor_count = count_q;
`endif

endmodule

// File: tb/tb_factorizer_serial.sv
// Directed scoreboard bench for factorizer_serial (8/9 and 12/16 instances).
module tb_factorizer_serial;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [7:0]  a_number;
  logic [7:0]  a_factors;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [11:0] b_number;
  logic [14:0] b_factors;
`ifdef FACTORIZER_COUNT_EN
  logic [3:0]  a_count;
  logic [3:0]  b_count;
`endif

  factorizer_serial #(.WIDTH(8), .MAX_DIV(9)) u_dut_a (
    .clk(clk), .reset(reset),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .number(a_number),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .factors(a_factors)
`ifdef FACTORIZER_COUNT_EN
    , .factor_count(a_count)
`endif
  );

  factorizer_serial #(.WIDTH(12), .MAX_DIV(16)) u_dut_b (
    .clk(clk), .reset(reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .number(b_number),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .factors(b_factors)
`ifdef FACTORIZER_COUNT_EN
    , .factor_count(b_count)
`endif
  );

  typedef struct {
    logic [31:0] mask;
    int          cnt;
  } exp_t;

  exp_t sb_q[$];
  int   errs   = 0;
  int   checks = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: direct modulo test for every divisor 2..maxdiv.
  function automatic logic [31:0] model(input int num, input int maxdiv);
    logic [31:0] m = '0;
    for (int d = 2; d <= maxdiv; d++) begin
      if (num % d == 0) m[d-2] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic ov(input int sel);
    return (sel != 0) ? b_out_valid : a_out_valid;
  endfunction

  function automatic logic ir(input int sel);
    return (sel != 0) ? b_in_ready : a_in_ready;
  endfunction

  function automatic logic [31:0] fac(input int sel);
    return (sel != 0) ? 32'(b_factors) : 32'(a_factors);
  endfunction

`ifdef FACTORIZER_COUNT_EN
  function automatic logic [31:0] fcnt(input int sel);
    return (sel != 0) ? 32'(b_count) : 32'(a_count);
  endfunction
`endif

  task automatic set_in(input int sel, input logic v, input int num);
    if (sel != 0) begin
      b_in_valid = v;
      b_number   = 12'(num);
    end else begin
      a_in_valid = v;
      a_number   = 8'(num);
    end
  endtask

  task automatic set_or(input int sel, input logic v);
    if (sel != 0) b_out_ready = v;
    else          a_out_ready = v;
  endtask

  task automatic accept_num(input int sel, input int num, input bit expect_result);
    exp_t e;
    int   n = 0;
    int   maxdiv = (sel != 0) ? 16 : 9;
    while (!ir(sel) && n < 32) begin
      tick();
      n++;
    end
    check("in_ready_before_accept", 32'(ir(sel)), 32'd1);
    set_in(sel, 1'b1, num);
    tick();
    set_in(sel, 1'b0, 0);
    check("in_ready_after_accept", 32'(ir(sel)), 32'd0);
    if (expect_result) begin
      e.mask = model(num, maxdiv);
      e.cnt  = $countones(e.mask);
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_result(input int sel, input int lat, input bit consume);
    exp_t e;
    int   n = 0;
    while (!ov(sel) && n < 64) begin
      tick();
      n++;
    end
    check("latency", 32'(n), 32'(lat));
    check("scoreboard_depth", 32'(sb_q.size()), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check("factors", fac(sel), e.mask);
`ifdef FACTORIZER_COUNT_EN
      check("factor_count", fcnt(sel), 32'(e.cnt));
`endif
    end
    if (consume) begin
      set_or(sel, 1'b1);
      tick();
      set_or(sel, 1'b0);
      check("out_valid_after_consume", 32'(ov(sel)), 32'd0);
      check("in_ready_after_consume", 32'(ir(sel)), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    reset = 1'b1;
    set_in(0, 1'b0, 0);
    set_in(1, 1'b0, 0);
    set_or(0, 1'b0);
    set_or(1, 1'b0);
    repeat (3) tick();
    check("rst_in_ready_a", 32'(a_in_ready), 32'd0);
    check("rst_out_valid_a", 32'(a_out_valid), 32'd0);
    check("rst_factors_a", fac(0), 32'd0);
    check("rst_in_ready_b", 32'(b_in_ready), 32'd0);
    check("rst_out_valid_b", 32'(b_out_valid), 32'd0);
`ifdef FACTORIZER_COUNT_EN
    check("rst_count_a", fcnt(0), 32'd0);
`endif
    reset = 1'b0;
    tick();
    check("in_ready_after_release_a", 32'(a_in_ready), 32'd1);
    check("in_ready_after_release_b", 32'(b_in_ready), 32'd1);

    // WIDTH=8, MAX_DIV=9 directed numbers.
    accept_num(0, 72, 1);  wait_result(0, 8, 1);
    accept_num(0, 0, 1);   wait_result(0, 8, 1);
    accept_num(0, 1, 1);   wait_result(0, 8, 1);
    accept_num(0, 97, 1);  wait_result(0, 8, 1);
    accept_num(0, 255, 1); wait_result(0, 8, 1);

    // Backpressure on 210 with a pending number 12.
    accept_num(0, 210, 1);
    wait_result(0, 8, 0);
    set_in(0, 1'b1, 12);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_factors", fac(0), 32'h3B);
      check("bp_in_ready", 32'(a_in_ready), 32'd0);
      check("bp_out_valid", 32'(a_out_valid), 32'd1);
    end
    set_or(0, 1'b1);
    tick();
    set_or(0, 1'b0);
    check("bp_consume_out_valid", 32'(a_out_valid), 32'd0);
    check("bp_consume_in_ready", 32'(a_in_ready), 32'd1);
    tick();
    set_in(0, 1'b0, 0);
    check("bp_accept_12", 32'(a_in_ready), 32'd0);
    sb_q.push_back('{mask: model(12, 9), cnt: $countones(model(12, 9))});
    wait_result(0, 8, 1);

    // Reset during the 4th RUN cycle of 72 discards the result.
    accept_num(0, 72, 0);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("midrun_rst_out_valid", 32'(a_out_valid), 32'd0);
    check("midrun_rst_in_ready", 32'(a_in_ready), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("midrun_release_in_ready", 32'(a_in_ready), 32'd1);
    check("midrun_release_factors", fac(0), 32'd0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (a_out_valid) pulses++;
      tick();
    end
    check("midrun_no_out_valid", 32'(pulses), 32'd0);
    accept_num(0, 210, 1); wait_result(0, 8, 1);

    // WIDTH=12, MAX_DIV=16 instance.
    accept_num(1, 4095, 1); wait_result(1, 12, 1);
    accept_num(1, 2520, 1); wait_result(1, 12, 1);
    accept_num(1, 1, 1);    wait_result(1, 12, 1);
    accept_num(1, 0, 1);    wait_result(1, 12, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
